// File: rtl/pong_pkg.sv
// Shared encodings and screen geometry for the pong game controller, renderer and indicators.
package pong_pkg;

    typedef enum logic [1:0] {
        QI      = 2'b00,
        QGAME_1 = 2'b01,
        QGAME_2 = 2'b10,
        QDONE   = 2'b11
    } game_state_t;

    // Positive direction is right on X and down on Y.
    typedef enum logic {
        DIR_POS = 1'b0,
        DIR_NEG = 1'b1
    } dir_t;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int CENTRE_X = 320;
    localparam int CENTRE_Y = 240;

    function automatic logic in_window(input logic [9:0] a, input logic [9:0] b,
                                       input logic [9:0] half);
        logic [9:0] diff;
        diff = (a >= b) ? (a - b) : (b - a);
        return diff <= half;
    endfunction

endpackage

// File: rtl/pong_game_ctrl_if.sv
// Player-input and game-output bundle between the board I/O and the pong game controller.
interface pong_game_ctrl_if;
    import pong_pkg::*;

    logic        tick;
    logic        start;
    logic        p1_up;
    logic        p1_dn;
    logic        p2_up;
    logic        p2_dn;
    logic [9:0]  paddle1_y;
    logic [9:0]  paddle2_y;
    logic [9:0]  ball_x;
    logic [9:0]  ball_y;
    logic [3:0]  p1_score;
    logic [3:0]  p2_score;
    game_state_t state;

    modport master (
        output tick, start, p1_up, p1_dn, p2_up, p2_dn,
        input  paddle1_y, paddle2_y, ball_x, ball_y, p1_score, p2_score, state
    );

    modport slave (
        input  tick, start, p1_up, p1_dn, p2_up, p2_dn,
        output paddle1_y, paddle2_y, ball_x, ball_y, p1_score, p2_score, state
    );

endinterface

// File: rtl/pong_paddle.sv
// Clamped up/down paddle mover; pressing both or neither button holds position.
module pong_paddle #(
    parameter int PY_MIN = 16,
    parameter int PY_MAX = 464,
    parameter int STEP   = 2,
    parameter int Y_INIT = 240
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_en,
    input  logic       i_clear,
    input  logic       i_up,
    input  logic       i_dn,
    output logic [9:0] o_y
);

    localparam logic [9:0] C_MIN  = 10'(PY_MIN);
    localparam logic [9:0] C_MAX  = 10'(PY_MAX);
    localparam logic [9:0] C_STEP = 10'(STEP);
    localparam logic [9:0] C_INIT = 10'(Y_INIT);

    logic [9:0] r_y;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_y <= C_INIT;
        end else if (i_clear) begin
            r_y <= C_INIT;
        end else if (i_en && (i_up != i_dn)) begin
            if (i_up) begin
                r_y <= (r_y <= C_MIN + C_STEP) ? C_MIN : r_y - C_STEP;
            end else begin
                r_y <= (r_y + C_STEP >= C_MAX) ? C_MAX : r_y + C_STEP;
            end
        end
    end

    assign o_y = r_y;

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game logic: paddles, ball motion, scoring and game state, advanced on each tick.
// Optional PONG_SPEEDUP_EN: ball step grows by one per paddle hit (max 6), reset on every point.
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int PY_MIN      = 16,
    parameter int PY_MAX      = 464,
    parameter int PADDLE_STEP = 2,
    parameter int PADDLE_HALF = 10,
    parameter int P1_X        = 16,
    parameter int P2_X        = 624,
    parameter int BY_MIN      = 8,
    parameter int BY_MAX      = 472,
    parameter int BALL_STEP   = 2,
    parameter int SERVE_TICKS = 32,
    parameter int WIN_SCORE   = 10
) (
    input  logic             clk,
    input  logic             reset,
    pong_game_ctrl_if.slave  bus
);

    localparam int SW = $clog2(SERVE_TICKS + 1);

    localparam logic [9:0]    C_P1_X      = 10'(P1_X);
    localparam logic [9:0]    C_P2_X      = 10'(P2_X);
    localparam logic [9:0]    C_BY_MIN    = 10'(BY_MIN);
    localparam logic [9:0]    C_BY_MAX    = 10'(BY_MAX);
    localparam logic [9:0]    C_HALF      = 10'(PADDLE_HALF);
    localparam logic [9:0]    C_CENTRE_X  = 10'(CENTRE_X);
    localparam logic [9:0]    C_CENTRE_Y  = 10'(CENTRE_Y);
    localparam logic [SW-1:0] C_SERVE     = SW'(SERVE_TICKS);
    localparam logic [3:0]    C_WIN       = 4'(WIN_SCORE);

    game_state_t   r_state;
    logic [9:0]    r_bx;
    logic [9:0]    r_by;
    dir_t          r_dx;
    dir_t          r_dy;
    logic [3:0]    r_p1_score;
    logic [3:0]    r_p2_score;
    logic [SW-1:0] r_serve;

    logic       w_in_game;
    logic       w_pad_en;
    logic       w_pad_clear;
    logic [1:0] w_pad_up;
    logic [1:0] w_pad_dn;
    logic [9:0] w_pad_y [2];
    logic [9:0] w_step;

    logic       w_near_left;
    logic       w_near_right;
    logic       w_win1;
    logic       w_win2;
    logic [9:0] w_bx_next;
    logic [9:0] w_by_next;
    dir_t       w_dx_next;
    dir_t       w_dy_next;
    logic       w_point_p1;
    logic       w_point_p2;

    assign w_in_game   = (r_state == QGAME_1) || (r_state == QGAME_2);
    assign w_pad_en    = bus.tick && w_in_game;
    assign w_pad_clear = bus.tick && (r_state == QDONE) && !bus.start;
    assign w_pad_up    = {bus.p2_up, bus.p1_up};
    assign w_pad_dn    = {bus.p2_dn, bus.p1_dn};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_paddle
            pong_paddle #(
                .PY_MIN (PY_MIN),
                .PY_MAX (PY_MAX),
                .STEP   (PADDLE_STEP),
                .Y_INIT (CENTRE_Y)
            ) u_paddle (
                .clk     (clk),
                .reset   (reset),
                .i_en    (w_pad_en),
                .i_clear (w_pad_clear),
                .i_up    (w_pad_up[gi]),
                .i_dn    (w_pad_dn[gi]),
                .o_y     (w_pad_y[gi])
            );
        end
    endgenerate

`ifdef PONG_SPEEDUP_EN
    logic [2:0] r_speed;
    logic       w_hit;
    assign w_step = {7'd0, r_speed};
    assign w_hit  = (r_serve == '0) &&
                    (((r_dx == DIR_NEG) && w_near_left  && w_win1) ||
                     ((r_dx == DIR_POS) && w_near_right && w_win2));
`else
    assign w_step = 10'(BALL_STEP);
`endif

    // Hit test uses the paddle positions from before this tick's paddle move.
    assign w_near_left  = (r_bx <= C_P1_X + w_step);
    assign w_near_right = (r_bx + w_step >= C_P2_X);
    assign w_win1       = in_window(r_by, w_pad_y[0], C_HALF);
    assign w_win2       = in_window(r_by, w_pad_y[1], C_HALF);

    always_comb begin
        w_by_next  = r_by;
        w_dy_next  = r_dy;
        w_bx_next  = r_bx;
        w_dx_next  = r_dx;
        w_point_p1 = 1'b0;
        w_point_p2 = 1'b0;

        if (r_dy == DIR_POS) begin
            if (r_by + w_step >= C_BY_MAX) begin
                w_by_next = C_BY_MAX;
                w_dy_next = DIR_NEG;
            end else begin
                w_by_next = r_by + w_step;
            end
        end else begin
            if (r_by <= C_BY_MIN + w_step) begin
                w_by_next = C_BY_MIN;
                w_dy_next = DIR_POS;
            end else begin
                w_by_next = r_by - w_step;
            end
        end

        if (r_dx == DIR_NEG) begin
            if (w_near_left) begin
                if (w_win1) begin
                    w_bx_next = C_P1_X;
                    w_dx_next = DIR_POS;
                end else begin
                    w_point_p2 = 1'b1;
                end
            end else begin
                w_bx_next = r_bx - w_step;
            end
        end else begin
            if (w_near_right) begin
                if (w_win2) begin
                    w_bx_next = C_P2_X;
                    w_dx_next = DIR_NEG;
                end else begin
                    w_point_p1 = 1'b1;
                end
            end else begin
                w_bx_next = r_bx + w_step;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= QI;
            r_bx       <= C_CENTRE_X;
            r_by       <= C_CENTRE_Y;
            r_dx       <= DIR_POS;
            r_dy       <= DIR_POS;
            r_p1_score <= 4'd0;
            r_p2_score <= 4'd0;
            r_serve    <= C_SERVE;
`ifdef PONG_SPEEDUP_EN
            r_speed    <= 3'(BALL_STEP);
`endif
        end else if (bus.tick) begin
            case (r_state)
                QI: begin
                    if (bus.start) begin
                        r_state <= QGAME_1;
                        r_serve <= C_SERVE;
                    end
                end
                QGAME_1, QGAME_2: begin
                    if (r_serve != '0) begin
                        r_serve <= r_serve - 1'b1;
                    end else if (w_point_p1 || w_point_p2) begin
`ifdef PONG_SPEEDUP_EN
                        r_speed <= 3'(BALL_STEP);
`endif
                        if (w_point_p2) r_p2_score <= r_p2_score + 4'd1;
                        else            r_p1_score <= r_p1_score + 4'd1;
                        // Winning point freezes the ball where it stood.
                        if (w_point_p2 ? (r_p2_score + 4'd1 == C_WIN)
                                       : (r_p1_score + 4'd1 == C_WIN)) begin
                            r_state <= QDONE;
                        end else begin
                            r_bx    <= C_CENTRE_X;
                            r_by    <= C_CENTRE_Y;
                            r_dy    <= DIR_POS;
                            r_serve <= C_SERVE;
                            r_state <= w_point_p2 ? QGAME_1 : QGAME_2;
                            r_dx    <= w_point_p2 ? DIR_POS : DIR_NEG;
                        end
                    end else begin
                        r_bx <= w_bx_next;
                        r_by <= w_by_next;
                        r_dx <= w_dx_next;
                        r_dy <= w_dy_next;
`ifdef PONG_SPEEDUP_EN
                        if (w_hit && (r_speed < 3'd6)) r_speed <= r_speed + 3'd1;
`endif
                    end
                end
                QDONE: begin
                    if (!bus.start) begin
                        r_state    <= QI;
                        r_bx       <= C_CENTRE_X;
                        r_by       <= C_CENTRE_Y;
                        r_dx       <= DIR_POS;
                        r_dy       <= DIR_POS;
                        r_p1_score <= 4'd0;
                        r_p2_score <= 4'd0;
                        r_serve    <= C_SERVE;
`ifdef PONG_SPEEDUP_EN
                        r_speed    <= 3'(BALL_STEP);
`endif
                    end
                end
                default: r_state <= QI;
            endcase
        end
    end

    assign bus.paddle1_y = w_pad_y[0];
    assign bus.paddle2_y = w_pad_y[1];
    assign bus.ball_x    = r_bx;
    assign bus.ball_y    = r_by;
    assign bus.p1_score  = r_p1_score;
    assign bus.p2_score  = r_p2_score;
    assign bus.state     = r_state;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Randomised bench for pong_game_ctrl: driver feeds a game-rule model, monitor checks every edge.
module tb_pong_game_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    pong_game_ctrl_if u_if ();

    pong_game_ctrl u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if.slave)
    );

    typedef struct {
        int p1, p2, bx, by, s1, s2, st;
    } exp_t;

    exp_t exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    // Reference game state: directions are +1 (right/down) or -1 (left/up).
    int m_p1, m_p2, m_bx, m_by, m_dx, m_dy, m_s1, m_s2, m_state, m_serve, m_spd;
    int games_done = 0;

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int pmove(input int y, input bit up, input bit dn);
        if (up && !dn) return (y - 2 < 16) ? 16 : y - 2;
        if (dn && !up) return (y + 2 > 464) ? 464 : y + 2;
        return y;
    endfunction

    task automatic model_reset();
        m_p1 = 240; m_p2 = 240; m_bx = 320; m_by = 240;
        m_dx = 1; m_dy = 1; m_s1 = 0; m_s2 = 0;
        m_state = 0; m_serve = 32; m_spd = 2;
    endtask

    task automatic model_tick(input bit st, input bit u1, input bit d1,
                              input bit u2, input bit d2);
        int op1, op2, nbx, nby, ndx, ndy, winner;
        bit hit;
        op1 = m_p1; op2 = m_p2;
        case (m_state)
            0: if (st) begin m_state = 1; m_serve = 32; end
            1, 2: begin
                m_p1 = pmove(m_p1, u1, d1);
                m_p2 = pmove(m_p2, u2, d2);
                if (m_serve > 0) begin
                    m_serve--;
                end else begin
                    winner = 0; hit = 0;
                    ndy = m_dy;
                    nby = m_by + m_dy * m_spd;
                    if (nby >= 472) begin nby = 472; ndy = -1; end
                    else if (nby <= 8) begin nby = 8; ndy = 1; end
                    ndx = m_dx;
                    nbx = m_bx + m_dx * m_spd;
                    if (m_dx < 0 && nbx <= 16) begin
                        if (iabs(m_by - op1) <= 10) begin nbx = 16; ndx = 1; hit = 1; end
                        else winner = 2;
                    end else if (m_dx > 0 && nbx >= 624) begin
                        if (iabs(m_by - op2) <= 10) begin nbx = 624; ndx = -1; hit = 1; end
                        else winner = 1;
                    end
                    if (winner == 0) begin
                        m_bx = nbx; m_by = nby; m_dx = ndx; m_dy = ndy;
`ifdef PONG_SPEEDUP_EN
                        if (hit && m_spd < 6) m_spd++;
`endif
                    end else begin
                        m_spd = 2;
                        if (winner == 1) m_s1++; else m_s2++;
                        if (m_s1 == 10 || m_s2 == 10) begin
                            m_state = 3;
                            games_done++;
                        end else begin
                            m_bx = 320; m_by = 240; m_dy = 1; m_serve = 32;
                            m_state = (winner == 2) ? 1 : 2;
                            m_dx    = (winner == 2) ? 1 : -1;
                        end
                    end
                end
            end
            default: if (!st) model_reset();
        endcase
    endtask

    task automatic push_expected();
        exp_t e;
        e.p1 = m_p1; e.p2 = m_p2; e.bx = m_bx; e.by = m_by;
        e.s1 = m_s1; e.s2 = m_s2; e.st = m_state;
        exp_q.push_back(e);
    endtask

    task automatic check_reset_vals(input string tag);
        n_checks++;
        if (u_if.paddle1_y == 10'd240 && u_if.paddle2_y == 10'd240 &&
            u_if.ball_x == 10'd320 && u_if.ball_y == 10'd240 &&
            u_if.p1_score == 4'd0 && u_if.p2_score == 4'd0 && u_if.state == 2'b00)
            n_pass++;
        else
            $display("FAIL %s: got pad=(%0d,%0d) ball=(%0d,%0d) score=%0d:%0d st=%0d, required pad=(240,240) ball=(320,240) score=0:0 st=0",
                     tag, u_if.paddle1_y, u_if.paddle2_y, u_if.ball_x, u_if.ball_y,
                     u_if.p1_score, u_if.p2_score, u_if.state);
    endtask

    // Monitor: one expected entry per clocked update, compared just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if (int'(u_if.paddle1_y) == e.p1 && int'(u_if.paddle2_y) == e.p2 &&
                    int'(u_if.ball_x) == e.bx && int'(u_if.ball_y) == e.by &&
                    int'(u_if.p1_score) == e.s1 && int'(u_if.p2_score) == e.s2 &&
                    int'(u_if.state) == e.st) begin
                    n_pass++;
                end else begin
                    $display("FAIL outputs @%0t: got pad=(%0d,%0d) ball=(%0d,%0d) score=%0d:%0d st=%0d, required pad=(%0d,%0d) ball=(%0d,%0d) score=%0d:%0d st=%0d",
                             $time, u_if.paddle1_y, u_if.paddle2_y, u_if.ball_x, u_if.ball_y,
                             u_if.p1_score, u_if.p2_score, u_if.state,
                             e.p1, e.p2, e.bx, e.by, e.s1, e.s2, e.st);
                end
            end
        end
    end

    // Driver: random inputs, paddles loosely track the ball so rallies contain hits and misses.
    initial begin
        bit mid_reset_done = 0;
        int cyc = 0;
        bit t, st, u1, d1, u2, d2;
        int start_pct;

        u_if.tick = 1'b0; u_if.start = 1'b0;
        u_if.p1_up = 1'b0; u_if.p1_dn = 1'b0; u_if.p2_up = 1'b0; u_if.p2_dn = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_vals("power_on_reset");
        reset = 1'b0;

        while (games_done < 2 && cyc < 60000) begin
            if (games_done == 1 && !mid_reset_done && (m_state == 1 || m_state == 2) &&
                m_serve == 0 && m_bx != 320) begin
                mid_reset_done = 1;
                @(posedge clk);
                #3;
                u_if.tick = 1'b0;
                reset = 1'b1;
                #1;
                check_reset_vals("async_reset_mid_rally");
                model_reset();
                @(negedge clk);
                reset = 1'b0;
            end
            @(negedge clk);
            cyc++;
            t = ($urandom_range(0, 9) != 0);
            start_pct = (m_state == 3) ? 80 : (m_state == 0) ? 40 : 50;
            st = ($urandom_range(0, 99) < start_pct);
            if ($urandom_range(0, 99) < 55) begin
                u1 = (m_by < m_p1); d1 = (m_by > m_p1);
            end else begin
                u1 = $urandom_range(0, 1); d1 = $urandom_range(0, 1);
            end
            if ($urandom_range(0, 99) < 55) begin
                u2 = (m_by < m_p2); d2 = (m_by > m_p2);
            end else begin
                u2 = $urandom_range(0, 1); d2 = $urandom_range(0, 1);
            end
            u_if.tick = t; u_if.start = st;
            u_if.p1_up = u1; u_if.p1_dn = d1; u_if.p2_up = u2; u_if.p2_dn = d2;
            if (t) model_tick(st, u1, d1, u2, d2);
            push_expected();
        end

        repeat (3) @(negedge clk);
        if (games_done < 2) begin
            n_checks++;
            $display("FAIL game_completion: got %0d finished games within %0d cycles, required 2",
                     games_done, cyc);
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pong_game_ctrl.md
Name: pong_game_ctrl

Overview:
- Game-logic stage directly upstream of the VGA renderer and the LD/SSD indicators.
- Owns both paddle positions, ball position and direction, both scores, and the 2-bit game state.
- The renderer only draws what this block outputs; LD/SSD decode the state and scores.
- All motion advances on a one-cycle `tick` enable (derived externally from the clock divider); there is no second clock.

Parameters:
- PY_MIN, 16: minimum paddle centre Y.
- PY_MAX, 464: maximum paddle centre Y.
- PADDLE_STEP, 2: paddle move per tick.
- PADDLE_HALF, 10: paddle half-height; hit window is |ball_y - paddle_y| <= PADDLE_HALF.
- P1_X, 16: left paddle face X.
- P2_X, 624: right paddle face X.
- BY_MIN, 8: ball Y top bound.
- BY_MAX, 472: ball Y bottom bound.
- BALL_STEP, 2: ball move per tick, each axis.
- SERVE_TICKS, 32: ticks the ball is frozen at centre after reset of play or after a point.
- WIN_SCORE, 10: score that ends the game.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- tick  in  1  game-update enable, one clk wide.
- start  in  1  level; 1 = play, 0 = return to idle from DONE.
- p1_up  in  1  left paddle up.
- p1_dn  in  1  left paddle down.
- p2_up  in  1  right paddle up.
- p2_dn  in  1  right paddle down.
- paddle1_y  out  10  left paddle centre Y.
- paddle2_y  out  10  right paddle centre Y.
- ball_x  out  10  ball centre X.
- ball_y  out  10  ball centre Y.
- p1_score  out  4  left player score.
- p2_score  out  4  right player score.
- state  out  2  QI=00, QGAME_1=01, QGAME_2=10, QDONE=11.

Behaviour:
- Reset (async, active-high, clk is the only clock):
  - state=QI; paddles=240; ball=(320,240); scores=0.
  - dx=right, dy=down; serve counter=SERVE_TICKS.
- All outputs are registered. Nothing changes on cycles where tick=0.
- QI: hold the reset values. On tick with start=1 → QGAME_1, serve counter=SERVE_TICKS.
- QGAME_1 means left serves (dx=right); QGAME_2 means right serves (dx=left). Ball motion is identical in both states.
- Paddles, every tick in QGAME_x:
  - up only: y -= PADDLE_STEP, clamped at PY_MIN.
  - down only: y += PADDLE_STEP, clamped at PY_MAX.
  - both or neither: hold.
  - Paddles move during the serve freeze. In QI/QDONE paddles hold.
- Serve freeze: while the serve counter is non-zero, decrement it per tick; the ball holds.
- Ball Y, when the counter is 0:
  - Down: if ball_y+BALL_STEP >= BY_MAX then ball_y=BY_MAX and dy flips; else ball_y += BALL_STEP.
  - Up: mirror of the above against BY_MIN.
- Ball X, when the counter is 0:
  - Moving left: if ball_x-BALL_STEP <= P1_X, test the hit against the pre-update paddle1_y.
    - Hit: ball_x=P1_X, dx=right.
    - Miss: point to P2.
  - Otherwise ball_x -= BALL_STEP. Moving right is the mirror, against P2_X and paddle2_y.
  - X and Y resolve in the same tick, so a corner hit both bounces and reflects.
- Point to Pn:
  - pn_score += 1.
  - If the new value == WIN_SCORE → QDONE, ball frozen in place.
  - Else ball=(320,240), counter=SERVE_TICKS, dy=down.
  - Loser serves: point to P2 → QGAME_1, dx=right; point to P1 → QGAME_2, dx=left.
- Scores never exceed WIN_SCORE. Arithmetic is unsigned 10-bit; clamps prevent underflow.
- QDONE: hold all values. On tick with start=0 → QI, which restores all reset values.
- start=0 during QGAME_x has no effect; play continues. Only reset aborts a game mid-play.

Optional Feature:
- Macro: PONG_SPEEDUP_EN.
- Defined:
  - A 3-bit ball_speed register replaces BALL_STEP on both axes.
  - Starts at BALL_STEP; +1 on every paddle hit, saturating at 6.
  - Resets to BALL_STEP on every point and on reset.
- Undefined: constant BALL_STEP; no extra register.

Decomposition:
- pong_pkg holds:
  - state encodings QI/QGAME_1/QGAME_2/QDONE;
  - screen constants 640/480 and centre 320/240;
  - direction encodings.
- Renderer and LD logic import the same encodings.
- One natural sub-module, pong_paddle: clamped up/down mover, instantiated twice.

Test Plan (tick held at 1):
- Reset then start=1 → state 01 one cycle later; ball stays at (320,240) for 32 ticks, then moves to (322,242).
- Paddle clamp: p1_up held from paddle1_y=18 → 16 and stays 16. p1_up and p1_dn together → no change.
- Wall bounce: ball_y=470 moving down → 472 with dy=up, next tick 470.
- Left hit: force ball_x=18, dx=left, ball_y=paddle1_y+10 → ball_x=16, dx=right, scores unchanged.
- Left miss: ball_y=paddle1_y+11 → p2_score+1, ball=(320,240), state=QGAME_1, dx=right.
- Ninth-to-tenth point to P1 → p1_score=10, state=11. start=0 → state 00, scores 0. Assert reset mid-rally → all reset values immediately, without waiting for a clk edge.
